icache_dm: RTL and testbench

Direct-mapped, one-word-per-line, read-only instruction cache sitting between the pipelined datapath's instruction-fetch port and the memory controller. On a hit, it serves `imemREN`/`imemaddr` combinationally with `ihit`/`imemload`. On a miss, it runs a fill FSM that issues a single-word read to memory, waits out `iwait`, and installs the line. A synchronous `flush` invalidates every line.

---
 rtl/icache_dm.sv | 165 ++++++++++++++++
 tb/tb_icache_dm.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// ---------------------------------------------------------------------------
// icache_dm
// Direct-mapped, one-word-per-line, read-only instruction cache placed
// between the datapath fetch port and the memory controller.
//
// Hits are served combinationally in the same cycle as the request. A miss
// starts a two-state fill FSM that issues a single-word read to memory,
// holds it until memory stops asserting iwait, and then installs the line.
// Asserting flush invalidates every line at the next clock edge.
//
// Parameters
//   SETS      number of lines (power of 2, at least 2)
//
// Ports
//   CLK       clock, rising edge
//   nRST      asynchronous, active-low reset
//   imemREN   datapath fetch request
//   imemaddr  datapath fetch byte address (bits [1:0] ignored)
//   ihit      requested word is valid on imemload this cycle
//   imemload  instruction word read from the indexed line
//   flush     invalidate all lines
//   iREN      memory read request (only while filling)
//   iaddr     memory read word address, [1:0] = 0
//   iwait     memory busy; a read completes when iREN=1 and iwait=0
//   iload     memory read data, valid when iwait=0
// ---------------------------------------------------------------------------
module icache_dm #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t state;
    state_t next_state;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    logic [31:0]      data [SETS];

    // Word address of the line being filled; the byte offset is always zero,
    // so only the upper 30 bits are kept.
    logic [29:0]      fill_word;
    // Set when a flush lands during a fill so the returning word is discarded.
    logic             drop;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             lookup_hit;
    logic             start_fill;
    logic             fill_done;
    logic             install;

    // Byte offset bits are architecturally ignored by the fetch port.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^imemaddr[1:0];

    assign req_idx  = imemaddr[IDX_W+1:2];
    assign req_tag  = imemaddr[31:IDX_W+2];
    assign fill_idx = fill_word[IDX_W-1:0];
    assign fill_tag = fill_word[29:IDX_W];

    assign lookup_hit = valid[req_idx] && (tags[req_idx] == req_tag);

    // No bypass from iload: the word becomes visible only once written.
    assign imemload = data[req_idx];

    // A flush on the completion cycle also discards the returning word.
    assign install = fill_done && !drop && !flush;

    // Next-state and output decode. Lookups only count as hits in IDLE; a
    // flush in IDLE still reports hits against the pre-flush contents but
    // suppresses starting a fill that cycle.
    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        iREN       = 1'b0;
        iaddr      = 32'h0;
        start_fill = 1'b0;
        fill_done  = 1'b0;
        case (state)
            IDLE: begin
                ihit = imemREN && lookup_hit;
                if (imemREN && !lookup_hit && !flush) begin
                    start_fill = 1'b1;
                    next_state = FILL;
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = {fill_word, 2'b00};
                if (!iwait) begin
                    fill_done  = 1'b1;
                    next_state = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Fill bookkeeping: the missing address is latched when the fill starts
    // and stays put even if the datapath redirects mid-fill.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fill_word <= '0;
            drop      <= 1'b0;
        end else begin
            if (start_fill) begin
                fill_word <= imemaddr[31:2];
                drop      <= 1'b0;
            end else if (state == FILL && flush) begin
                drop      <= 1'b1;
            end
        end
    end

    // Line storage. Flush clears every valid bit; a completing fill that is
    // neither dropped nor coincident with a flush installs its line.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
            for (int i = 0; i < SETS; i++) begin
                tags[i] <= '0;
                data[i] <= '0;
            end
        end else begin
            if (flush) begin
                valid <= '0;
            end else if (install) begin
                valid[fill_idx] <= 1'b1;
            end
            if (install) begin
                tags[fill_idx] <= fill_tag;
                data[fill_idx] <= iload;
            end
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// ---------------------------------------------------------------------------
// tb_icache_dm
// Directed testbench for icache_dm (SETS=16). Inputs change 1 ns after each
// rising edge; combinational outputs are sampled 1 ns later, well away from
// the next edge. Memory behaviour is driven by hand per scenario.
// ---------------------------------------------------------------------------
module tb_icache_dm;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int checks;
    int errors;

    localparam logic [31:0] DATA_A = 32'h8C22_0000;
    localparam logic [31:0] DATA_B = 32'h1111_2222;
    localparam logic [31:0] DATA_D = 32'h2222_3333;
    localparam logic [31:0] DATA_E = 32'h3333_4444;
    localparam logic [31:0] DATA_F = 32'h4444_5555;

    icache_dm #(.SETS(16)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .flush    (flush),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to 1 ns after the next rising edge.
    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    // Drive a miss on addr and complete it after 'waits' busy cycles.
    // Returns in the IDLE cycle following completion with the request held.
    task automatic do_fill(input logic [31:0] addr, input logic [31:0] word, input int waits);
        imemREN  = 1'b1;
        imemaddr = addr;
        flush    = 1'b0;
        iwait    = 1'b1;
        cycle();
        for (int w = 0; w < waits; w++) cycle();
        iwait = 1'b0;
        iload = word;
        cycle();
        iwait = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h4; flush = 1'b0; iwait = 1'b1; iload = 32'h0;
        #2;
        checks++; if (ihit !== 1'b0) begin errors++; $display("[TB] FAIL reset_ihit: got %0b want 0", ihit); end
        checks++; if (imemload !== 32'h0) begin errors++; $display("[TB] FAIL reset_imemload: got %08h want 00000000", imemload); end
        checks++; if (iREN !== 1'b0) begin errors++; $display("[TB] FAIL reset_iREN: got %0b want 0", iREN); end
        checks++; if (iaddr !== 32'h0) begin errors++; $display("[TB] FAIL reset_iaddr: got %08h want 00000000", iaddr); end
        cycle();
        cycle();
        nRST = 1'b1;
        imemREN = 1'b0;
        cycle();
    endtask

    task automatic test_cold_miss();
        imemREN = 1'b1; imemaddr = 32'h4; iwait = 1'b1; iload = 32'h0;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("[TB] FAIL cold_c0_ihit: got %0b want 0", ihit); end
        checks++; if (iREN !== 1'b0) begin errors++; $display("[TB] FAIL cold_c0_iREN: got %0b want 0", iREN); end
        for (int c = 1; c <= 3; c++) begin
            cycle();
            if (c == 3) begin iwait = 1'b0; iload = DATA_A; end
            #1;
            checks++; if (ihit !== 1'b0) begin errors++; $display("[TB] FAIL cold_c%0d_ihit: got %0b want 0", c, ihit); end
            checks++; if (iREN !== 1'b1) begin errors++; $display("[TB] FAIL cold_c%0d_iREN: got %0b want 1", c, iREN); end
            checks++; if (iaddr !== 32'h4) begin errors++; $display("[TB] FAIL cold_c%0d_iaddr: got %08h want 00000004", c, iaddr); end
        end
        cycle();
        iwait = 1'b1; iload = 32'hDEAD_BEEF;
        #1;
        checks++; if (ihit !== 1'b1) begin errors++; $display("[TB] FAIL cold_c4_ihit: got %0b want 1", ihit); end
        checks++; if (imemload !== DATA_A) begin errors++; $display("[TB] FAIL cold_c4_imemload: got %08h want %08h", imemload, DATA_A); end
        checks++; if (iREN !== 1'b0) begin errors++; $display("[TB] FAIL cold_c4_iREN: got %0b want 0", iREN); end
        imemREN = 1'b0;
        cycle();
    endtask

    task automatic test_conflict();
        imemREN = 1'b1; imemaddr = 32'h4;
        #1;
        checks++; if (ihit !== 1'b1) begin errors++; $display("[TB] FAIL conf_pre_hit: got %0b want 1", ihit); end
        do_fill(32'h44, DATA_B, 1);
        #1;
        checks++; if (ihit !== 1'b1) begin errors++; $display("[TB] FAIL conf_b_hit: got %0b want 1", ihit); end
        checks++; if (imemload !== DATA_B) begin errors++; $display("[TB] FAIL conf_b_data: got %08h want %08h", imemload, DATA_B); end
        imemaddr = 32'h4;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("[TB] FAIL conf_a_evicted: got %0b want 0", ihit); end
        cycle();
        #1;
        checks++; if (iREN !== 1'b1) begin errors++; $display("[TB] FAIL conf_refill_iREN: got %0b want 1", iREN); end
        checks++; if (iaddr !== 32'h4) begin errors++; $display("[TB] FAIL conf_refill_iaddr: got %08h want 00000004", iaddr); end
        iwait = 1'b0; iload = DATA_A;
        cycle();
        iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b1 || imemload !== DATA_A) begin errors++; $display("[TB] FAIL conf_a_back: got hit=%0b data=%08h want hit=1 data=%08h", ihit, imemload, DATA_A); end
        imemaddr = 32'h44;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("[TB] FAIL conf_b_evicted: got %0b want 0", ihit); end
        imemREN = 1'b0;
        cycle();
    endtask

    task automatic test_redirect();
        imemREN = 1'b1; imemaddr = 32'h10; iwait = 1'b1;
        cycle();
        imemaddr = 32'h20;
        #1;
        checks++; if (iaddr !== 32'h10 || iREN !== 1'b1) begin errors++; $display("[TB] FAIL redir_hold1: got iREN=%0b iaddr=%08h want iREN=1 iaddr=00000010", iREN, iaddr); end
        checks++; if (ihit !== 1'b0) begin errors++; $display("[TB] FAIL redir_fill_ihit: got %0b want 0", ihit); end
        cycle();
        iwait = 1'b0; iload = DATA_D;
        #1;
        checks++; if (iaddr !== 32'h10) begin errors++; $display("[TB] FAIL redir_hold2: got %08h want 00000010", iaddr); end
        cycle();
        iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b0 || iREN !== 1'b0) begin errors++; $display("[TB] FAIL redir_idle_miss: got hit=%0b iREN=%0b want hit=0 iREN=0", ihit, iREN); end
        cycle();
        #1;
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h20) begin errors++; $display("[TB] FAIL redir_new_fill: got iREN=%0b iaddr=%08h want iREN=1 iaddr=00000020", iREN, iaddr); end
        iwait = 1'b0; iload = DATA_E;
        cycle();
        iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b1 || imemload !== DATA_E) begin errors++; $display("[TB] FAIL redir_new_hit: got hit=%0b data=%08h want hit=1 data=%08h", ihit, imemload, DATA_E); end
        imemaddr = 32'h10;
        #1;
        checks++; if (ihit !== 1'b1 || imemload !== DATA_D) begin errors++; $display("[TB] FAIL redir_old_installed: got hit=%0b data=%08h want hit=1 data=%08h", ihit, imemload, DATA_D); end
        imemREN = 1'b0;
        cycle();
    endtask

    task automatic test_flush_fill();
        imemREN = 1'b1; imemaddr = 32'h8; iwait = 1'b1;
        cycle();
        cycle();
        flush = 1'b1;
        #1;
        checks++; if (iREN !== 1'b1) begin errors++; $display("[TB] FAIL flfill_iREN: got %0b want 1", iREN); end
        cycle();
        flush = 1'b0; iwait = 1'b0; iload = DATA_F;
        #1;
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h8) begin errors++; $display("[TB] FAIL flfill_complete: got iREN=%0b iaddr=%08h want iREN=1 iaddr=00000008", iREN, iaddr); end
        cycle();
        iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b0 || imemload !== 32'h0) begin errors++; $display("[TB] FAIL flfill_not_installed: got hit=%0b data=%08h want hit=0 data=00000000", ihit, imemload); end
        imemaddr = 32'h4;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("[TB] FAIL flfill_4_gone: got %0b want 0", ihit); end
        imemaddr = 32'h10;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("[TB] FAIL flfill_10_gone: got %0b want 0", ihit); end
        imemaddr = 32'h20;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("[TB] FAIL flfill_20_gone: got %0b want 0", ihit); end
        imemaddr = 32'h8;
        cycle();
        #1;
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h8) begin errors++; $display("[TB] FAIL flfill_refetch: got iREN=%0b iaddr=%08h want iREN=1 iaddr=00000008", iREN, iaddr); end
        iwait = 1'b0; iload = DATA_F;
        cycle();
        iwait = 1'b1;
        #1;
        checks++; if (ihit !== 1'b1 || imemload !== DATA_F) begin errors++; $display("[TB] FAIL flfill_refill_hit: got hit=%0b data=%08h want hit=1 data=%08h", ihit, imemload, DATA_F); end
        imemREN = 1'b0;
        cycle();
    endtask

    task automatic test_flush_idle();
        imemREN = 1'b1; imemaddr = 32'h8; flush = 1'b1;
        #1;
        checks++; if (ihit !== 1'b1) begin errors++; $display("[TB] FAIL flidle_prehit: got %0b want 1", ihit); end
        imemaddr = 32'h30;
        cycle();
        flush = 1'b0;
        #1;
        checks++; if (iREN !== 1'b0) begin errors++; $display("[TB] FAIL flidle_no_fill: got %0b want 0", iREN); end
        imemaddr = 32'h8;
        #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("[TB] FAIL flidle_invalidated: got %0b want 0", ihit); end
        imemREN = 1'b0;
        cycle();
    endtask

    task automatic test_idle_request();
        do_fill(32'h4, DATA_A, 0);
        imemREN = 1'b0;
        iwait = 1'b0;
        for (int i = 0; i < 12; i++) begin
            imemaddr = 32'(i * 4);
            #1;
            checks++; if (ihit !== 1'b0 || iREN !== 1'b0) begin errors++; $display("[TB] FAIL idle_req_%0d: got hit=%0b iREN=%0b want hit=0 iREN=0", i, ihit, iREN); end
            cycle();
        end
        iwait = 1'b1;
    endtask

    task automatic test_reset_mid_fill();
        imemREN = 1'b1; imemaddr = 32'h4;
        #1;
        checks++; if (ihit !== 1'b1) begin errors++; $display("[TB] FAIL rstfill_prehit: got %0b want 1", ihit); end
        imemaddr = 32'hC; iwait = 1'b1;
        cycle();
        #1;
        checks++; if (iREN !== 1'b1) begin errors++; $display("[TB] FAIL rstfill_in_fill: got %0b want 1", iREN); end
        #1;
        nRST = 1'b0;
        #1;
        checks++; if (iREN !== 1'b0 || iaddr !== 32'h0 || ihit !== 1'b0) begin errors++; $display("[TB] FAIL rstfill_async: got iREN=%0b iaddr=%08h hit=%0b want 0/00000000/0", iREN, iaddr, ihit); end
        imemaddr = 32'h4;
        cycle();
        nRST = 1'b1;
        #1;
        checks++; if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0) begin errors++; $display("[TB] FAIL rstfill_after: got hit=%0b data=%08h iREN=%0b want 0/00000000/0", ihit, imemload, iREN); end
        imemREN = 1'b0;
        cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_cold_miss();
        test_conflict();
        test_redirect();
        test_flush_fill();
        test_flush_idle();
        test_idle_request();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
